rptr_empty_fwft: RTL
====================

# rptr_empty_fwft

Read-side pointer, empty-flag and first-word-fall-through (FWFT) output stage of the parameterized asynchronous FIFO, in the read clock domain. It is the counterpart of the write-pointer/full logic. It holds the binary and Gray read pointers, compares them against the write pointer (already two-flop synchronized into rclk), and drives the memory read address. It prefetches the head entry into an output register with a valid/ready handshake, and reports a registered fill level and an almost-empty flag.

## Interface
- ADDRSIZE, 4, memory address width; depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits
- DATASIZE, 8, data word width
- AEMPTY_THRESH, 2, raempty asserts when memory level ≤ this value (0..2^ADDRSIZE)

- rclk  input  1  read clock; single clock for the whole block
- rrst_n  input  1  asynchronous, active-low reset
- rq2_wptr  input  ADDRSIZE+1  Gray write pointer, synchronized into rclk
- rdata_mem  input  DATASIZE  memory read data at raddr (combinational read port)
- dout_ready  input  1  consumer accepts dout this cycle
- raddr  output  ADDRSIZE  memory read address = rbin[ADDRSIZE-1:0]
- rptr  output  ADDRSIZE+1  registered Gray read pointer, sent to the write-domain synchronizer
- rempty  output  1  memory holds no unread entry (the output register is excluded)
- dout  output  DATASIZE  head-of-FIFO data
- dout_valid  output  1  dout holds valid data
- raempty  output  1  registered almost-empty flag
- rlevel  output  ADDRSIZE+1  registered entry count in memory (0..2^ADDRSIZE)

## Operation
- Reset values: rbin=0, rptr=0, rempty=1, dout=0, dout_valid=0, rlevel=0, raempty=1.
- Internal pop: pop = ~rempty & (~dout_valid | dout_ready).
- Pointer update: rbinnext = rbin + pop; rgraynext = (rbinnext>>1) ^ rbinnext. Each edge loads rbin←rbinnext and rptr←rgraynext.
- Empty flag: each edge loads rempty ← (rgraynext == rq2_wptr). The comparison uses the full ADDRSIZE+1 bits with no MSB inversion.
- Output stage:
  - On pop: dout←rdata_mem (read at the current raddr), dout_valid←1.
  - Else if dout_valid & dout_ready: dout_valid←0, dout holds.
  - Else: dout and dout_valid hold.
- Level: wbin = gray2bin(rq2_wptr). Each edge loads rlevel ← (wbin - rbinnext) mod 2^(ADDRSIZE+1) and raempty ← (that value ≤ AEMPTY_THRESH).
- rlevel is pessimistic because the write pointer is stale. It must never exceed the true level and never exceed 2^ADDRSIZE.
- Wrap-around: rbin wraps from 2^(ADDRSIZE+1)-1 to 0. The level arithmetic is modulo 2^(ADDRSIZE+1), so the wrap needs no special case.
- Consumer stall: when dout_valid=1 and dout_ready=0, no pop occurs, and raddr, rptr, dout and dout_valid all hold.
- Simultaneous accept and refill: when dout_valid=1, dout_ready=1 and rempty=0, the next word is loaded in the same edge and dout_valid stays 1. This gives full throughput of one word per rclk.
- Reset mid-operation: all state returns to reset values asynchronously. The prefetched word is discarded.

## Timing
- rq2_wptr change → rempty update: 1 rclk edge.
- rempty falling → dout_valid rising: 1 rclk edge.
- Total from a new rq2_wptr value to dout_valid=1 is 2 edges when the output register is empty.
- Accept-to-pointer: the edge that consumes a word also advances rptr by one Gray step. Only one rptr bit changes per edge.
- rlevel and raempty are registered and reflect rq2_wptr and rbinnext sampled at the same edge.
- dout_ready is sampled only at the rclk edge. dout_valid never deasserts without dout_ready=1.

## Structure
- Shared package/include holds:
  - functions bin2gray and gray2bin, parameterized by width;
  - localparam DEPTH = 1<<ADDRSIZE.
- The wptr_full logic uses these same functions.
- One sub-module is natural: fwft_out_reg (the dout/dout_valid handshake register, with pop as an input).
- The pointer/flag logic stays in the top module.

## Test plan
- Reset: assert rrst_n=0 mid-stream → immediately rempty=1, dout_valid=0, raempty=1, rlevel=0, rptr=0, raddr=0.
- Single word: from reset, drive rq2_wptr=5'b00001 with dout_ready=0 and mem[0]=8'hA5.
  - Edge 1: rempty=0.
  - Edge 2: dout=8'hA5, dout_valid=1, raddr=1, rptr=5'b00001, rempty=1.
  - dout and dout_valid hold until dout_ready=1; one edge later dout_valid=0.
- Streaming: rq2_wptr=gray(8)=5'b01100 with dout_ready held at 1 → 8 consecutive valid words, mem[0..7] in order, with no bubble; rlevel counts 7,6,…,0; raempty rises at rlevel ≤ 2.
- Stall: with 4 words available and dout_ready=0 for 5 cycles → raddr stays at 1 and rlevel=3; on release, the words drain in order.
- Wrap: write pointer advanced to bin 17 (Gray 5'b11001) across 17 pops → rptr ends at 5'b11001; raddr sequence is 0..15, 0; rempty=1 at the end; rlevel never exceeds 16.
- Full level: rq2_wptr=gray(16)=5'b11000 from reset with dout_ready=0 → rlevel=15 after the prefetch edge, raempty=0.

Source files
------------

// File: rtl/rptr_empty_fwft_pkg.sv
// Shared helpers for the async FIFO pointer logic: Gray conversions and default geometry.
// Used by both the read-side (rptr_empty_fwft) and write-side (wptr_full) blocks.
package rptr_empty_fwft_pkg;

    localparam int ADDRSIZE_DFLT = 4;
    localparam int DEPTH         = 1 << ADDRSIZE_DFLT;

    // Operands are zero-extended into 32 bits, so any pointer width up to 32 works.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty_fwft_out_reg.sv
// First-word-fall-through output register: holds the head word with a valid/ready handshake.
// A pop loads a new word even while the current one is being accepted, giving one word per clock.
module fwft_out_reg
    import rptr_empty_fwft_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pop,
    input  logic [DATASIZE-1:0] din,
    input  logic                dout_ready,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid
);

    // Output data/valid register: refill on pop, drop valid on a bare accept, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= {DATASIZE{1'b0}};
            dout_valid <= 1'b0;
        end else if (pop) begin
            dout       <= din;
            dout_valid <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout       <= dout;
            dout_valid <= 1'b0;
        end else begin
            dout       <= dout;
            dout_valid <= dout_valid;
        end
    end

endmodule

// File: rtl/rptr_empty_fwft.sv
// Read-domain pointer, empty/almost-empty flags and fill level of the async FIFO,
// feeding a prefetching FWFT output register.
module rptr_empty_fwft
    import rptr_empty_fwft_pkg::*;
#(
    parameter int          ADDRSIZE      = ADDRSIZE_DFLT,
    parameter int          DATASIZE      = 8,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] rdata_mem,
    input  logic                dout_ready,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel
);

    localparam int PW = ADDRSIZE + 1;

    logic [ADDRSIZE:0] rbin_r;
    logic              rempty_r;
    logic              pop_s;
    logic [ADDRSIZE:0] rbinnext_s;
    logic [ADDRSIZE:0] rgraynext_s;
    logic [ADDRSIZE:0] wbin_s;
    logic [ADDRSIZE:0] level_next_s;

    // Next-pointer and level arithmetic; the level wraps modulo 2^PW so pointer wrap is free.
    always_comb begin
        pop_s        = ~rempty_r & (~dout_valid | dout_ready);
        rbinnext_s   = rbin_r + PW'(pop_s);
        rgraynext_s  = PW'(bin2gray(32'(rbinnext_s)));
        wbin_s       = PW'(gray2bin(32'(rq2_wptr)));
        level_next_s = wbin_s - rbinnext_s;
    end

    // Pointer, empty flag and level registers; all compare against the synchronized write pointer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_r   <= {PW{1'b0}};
            rptr     <= {PW{1'b0}};
            rempty_r <= 1'b1;
            rlevel   <= {PW{1'b0}};
            raempty  <= 1'b1;
        end else begin
            rbin_r   <= rbinnext_s;
            rptr     <= rgraynext_s;
            rempty_r <= (rgraynext_s == rq2_wptr);
            rlevel   <= level_next_s;
            raempty  <= (32'(level_next_s) <= AEMPTY_THRESH);
        end
    end

    assign raddr  = rbin_r[ADDRSIZE-1:0];
    assign rempty = rempty_r;

    fwft_out_reg #(
        .DATASIZE (DATASIZE)
    ) u_out_reg (
        .clk        (rclk),
        .rst_n      (rrst_n),
        .pop        (pop_s),
        .din        (rdata_mem),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

endmodule
